// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S DAC transmitter (BCLK/LRCK/SDATA), mono by default, stereo with AUDIO_TX_STEREO_EN
module audio_i2s_tx #(
  parameter int BCLK_DIV = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic [SAMPLE_W-1:0] in_data_r,
  output logic                bclk,
  output logic                lrck,
  output logic                sdata,
  output logic                underrun,
  output logic                overrun
);
  localparam int FW = 2 * SAMPLE_W;
  localparam int SW = $clog2(FW);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  logic [DW-1:0]       div_cnt;
  logic [SW-1:0]       slot, slot_nx;
  logic [SAMPLE_W-1:0] hold, hold_r;
  logic [FW-1:0]       shift;
  logic                pending, wrap, fall, load, lr_nx;
  // Divider wrap, fall-event detection and next slot / word-select decode
  always_comb begin
    wrap    = div_cnt == DW'(BCLK_DIV - 1);
    fall    = wrap & bclk;
    load    = fall & (slot == SW'(FW - 1));
    slot_nx = (slot == SW'(FW - 1)) ? '0 : slot + SW'(1);
    lr_nx   = (slot_nx >= SW'(SAMPLE_W - 1)) & (slot_nx != SW'(FW - 1));
  end
  // Bit-clock divider: bclk toggles every BCLK_DIV clk cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DW'(1);
      if (wrap) bclk <= ~bclk;
    end
  end
  // Slot counter and serialiser; the MSB leaves directly at load so shift holds the remaining bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot  <= SW'(FW - 1);
      shift <= '0;
      sdata <= 1'b0;
      lrck  <= 1'b0;
    end else if (fall) begin
      slot <= slot_nx;
      lrck <= lr_nx;
      if (load) begin
        sdata <= hold[SAMPLE_W-1];
        shift <= {hold[SAMPLE_W-2:0], hold_r, 1'b0};
      end else begin
        sdata <= shift[FW-1];
        shift <= {shift[FW-2:0], 1'b0};
      end
    end
  end
  // Holding register with pending flag; a same-cycle load and strobe raises no flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold     <= '0;
      pending  <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      underrun <= load & ~pending & ~in_valid;
      overrun  <= in_valid & pending & ~load;
      pending  <= in_valid | (pending & ~load);
      if (in_valid) hold <= in_data;
    end
  end
`ifdef AUDIO_TX_STEREO_EN
  // Independent right-channel holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_r <= '0;
    else if (in_valid) hold_r <= in_data_r;
  end
`else
  logic unused_r;
  // Mono: right slot repeats the left sample
  always_comb hold_r = hold;
  assign unused_r = ^in_data_r;
`endif
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed self-checking bench for audio_i2s_tx
module tb_audio_i2s_tx;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [15:0] in_data = '0, in_data_r = '0;
  logic        bclk, lrck, sdata, underrun, overrun;
  int          n_chk = 0, n_fail = 0, ur_cnt = 0, ov_cnt = 0;
  logic [31:0] sd, lr;
  localparam logic [31:0] LR_MASK = 32'h0001_FFFE;

  audio_i2s_tx #(.BCLK_DIV(4), .SAMPLE_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_data_r(in_data_r),
    .bclk(bclk), .lrck(lrck), .sdata(sdata), .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Count flag pulses away from the active edge
  always @(negedge clk) begin
    if (underrun) ur_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Capture one frame starting at the slot-0 fall event; optional strobe 3 cycles in
  task automatic cap(input bit sv, input logic [15:0] v, output logic [31:0] s, output logic [31:0] l);
    for (int c = 0; c <= 248; c++) begin
      if (c % 8 == 0) begin
        s[31 - c / 8] = sdata;
        l[31 - c / 8] = lrck;
      end
      if (sv && c == 2) begin
        in_valid = 1'b1;
        in_data  = v;
      end
      if (c == 3) in_valid = 1'b0;
      if (c < 248) step(1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_ov", overrun, 0);
    @(negedge clk) reset = 1'b0;
    step(3);
    chk("bclk_c3", bclk, 0);
    step(1);
    chk("bclk_c4", bclk, 1);
    step(3);
    chk("bclk_c7", bclk, 1);
    chk("ur_c7", underrun, 0);
    step(1);
    chk("bclk_c8", bclk, 0);
    chk("ur_c8", underrun, 1);
    cap(0, 16'h0, sd, lr);
    chk("f1_sdata", sd, 32'h0);
    chk("f1_lrck", lr, LR_MASK);
    chk("f1_urcnt", ur_cnt, 1);
    step(1);
    in_valid = 1'b1;
    in_data  = 16'hA5C3;
    step(1);
    in_valid = 1'b0;
    step(6);
    cap(0, 16'h0, sd, lr);
    chk("a5c3_sdata", sd, 32'hA5C3_A5C3);
    chk("a5c3_lrck", lr, LR_MASK);
    chk("a5c3_urcnt", ur_cnt, 1);
    step(1);
    in_valid = 1'b1;
    in_data  = 16'h1111;
    step(1);
    in_data  = 16'h2222;
    step(1);
    in_valid = 1'b0;
    step(5);
    cap(0, 16'h0, sd, lr);
    chk("ovr_sdata", sd, 32'h2222_2222);
    chk("ovr_ovcnt", ov_cnt, 1);
    chk("ovr_urcnt", ur_cnt, 1);
    step(7);
    in_valid = 1'b1;
    in_data  = 16'h3333;
    step(1);
    in_valid = 1'b0;
    cap(0, 16'h0, sd, lr);
    chk("coll_sdata", sd, 32'h2222_2222);
    chk("coll_urcnt", ur_cnt, 1);
    chk("coll_ovcnt", ov_cnt, 1);
    step(8);
    cap(0, 16'h0, sd, lr);
    chk("coll_next", sd, 32'h3333_3333);
    chk("coll_next_ur", ur_cnt, 1);
    step(2);
    in_valid = 1'b1;
    in_data  = 16'h0000;
    step(1);
    in_valid = 1'b0;
    step(5);
    for (int i = 1; i <= 100; i++) begin
      cap(1, 16'(i), sd, lr);
      chk("ramp", sd, {16'(i - 1), 16'(i - 1)});
      step(8);
    end
    chk("ramp_urcnt", ur_cnt, 1);
    chk("ramp_ovcnt", ov_cnt, 1);
    step(84);
    chk("mid_sdata", sdata, 1);
    chk("mid_bclk", bclk, 1);
    reset = 1'b1;
    #1;
    chk("arst_bclk", bclk, 0);
    chk("arst_sdata", sdata, 0);
    chk("arst_lrck", lrck, 0);
    chk("arst_flags", {underrun, overrun}, 0);
    @(negedge clk) reset = 1'b0;
    step(8);
    chk("rs_bclk", bclk, 0);
    chk("rs_ur", underrun, 1);
    cap(0, 16'h0, sd, lr);
    chk("rs_sdata", sd, 32'h0);
    chk("rs_lrck", lr, LR_MASK);
    chk("rs_urcnt", ur_cnt, 2);
    step(1);
    in_valid  = 1'b1;
    in_data   = 16'h8000;
    in_data_r = 16'h0001;
    step(1);
    in_valid = 1'b0;
    step(6);
    cap(0, 16'h0, sd, lr);
`ifdef AUDIO_TX_STEREO_EN
    chk("lr_frame", sd, 32'h8000_0001);
`else
    chk("mono_frame", sd, 32'h8000_8000);
`endif
    chk("end_urcnt", ur_cnt, 2);
    chk("end_ovcnt", ov_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Serial DAC transmitter. Consumes the 16-bit two's-complement sample stream produced by the sound generator and drives an I2S DAC: BCLK, LRCK and SDATA.
- Sits at the top level between the sound block's SOUND output (strobed by the 96 kHz sample enable) and the board audio pins.
- Mono by default: one sample is sent on both channels.
- With CLK_AUDIO = 256·fs and BCLK_DIV = 4, one I2S frame is exactly one sample period.

Parameters:
- BCLK_DIV, 4: clk cycles per BCLK half-period. Must be ≥ 1.
- SAMPLE_W, 16: bits per channel slot. A frame is 2·SAMPLE_W BCLK periods.

Ports:
- clk  in  1  audio clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high. Clears all state immediately.
- in_valid  in  1  one-cycle strobe; in_data is valid this cycle.
- in_data  in  SAMPLE_W  left (or mono) sample, two's complement.
- in_data_r  in  SAMPLE_W  right sample. Used only when AUDIO_TX_STEREO_EN is defined.
- bclk  out  1  bit clock, registered.
- lrck  out  1  word select: 0 = left, 1 = right. Registered.
- sdata  out  1  serial data, MSB first, registered.
- underrun  out  1  one-cycle pulse: a frame started with no new sample.
- overrun  out  1  one-cycle pulse: an unconsumed sample was overwritten.

Behaviour:
- Reset values: bclk=0, lrck=0, sdata=0, underrun=0, overrun=0, div_cnt=0, slot=2·SAMPLE_W−1, hold=0, pending=0, shift=0.
- Divider:
  - div_cnt counts 0..BCLK_DIV−1 and wraps.
  - On wrap, bclk toggles.
  - Each 1→0 toggle is a "fall event"; all serial outputs update only on fall events.
  - The first fall event occurs 2·BCLK_DIV cycles after reset release.
- Slot counter:
  - On each fall event, slot increments mod 2·SAMPLE_W.
  - The first fall event after reset enters slot 0.
- Frame load, on the fall event entering slot 0:
  - shift ← {hold_L, hold_R}. In mono, hold_R = hold_L.
  - If pending=1: pending ← 0.
  - If pending=0: underrun pulses for 1 cycle and the last hold contents are retransmitted.
- I2S format, for slot k (N = SAMPLE_W):
  - sdata = L[N−1−k] for k < N.
  - sdata = R[2N−1−k] for k ≥ N.
  - lrck = 1 for k in N−1..2N−2, and 0 otherwise. LRCK therefore leads the channel's MSB by one BCLK.
  - sdata and lrck change together with bclk's falling edge, in the same clk cycle.
- Input holding register:
  - in_valid=1 → hold ← in_data (and in_data_r in stereo), pending ← 1.
  - If pending was already 1 and no frame load happens this cycle, overrun pulses for 1 cycle. The newest sample wins.
- Simultaneous in_valid and frame load in the same cycle:
  - The load takes the old hold.
  - The new sample is written to hold; pending ends at 1.
  - No overrun and no underrun pulse. If the old pending was 0, the load counts as a repeat but underrun is suppressed.
- Reset asserted mid-frame: outputs go to reset values asynchronously. The frame restarts cleanly at slot 0 after release.
- No flow control back to the source. The source rate must equal the frame rate; the flags expose any mismatch.

Optional Feature:
- Macro: AUDIO_TX_STEREO_EN.
- Defined: the in_data_r port drives the right slot independently.
- Undefined: in_data_r is ignored (tie off externally), and in_data is sent in both slots.
- The handshake and flags are identical in both builds.

Test Plan:
- Reset release, no input → first bclk rise at clk cycle 4 and fall at 8. underrun pulses at cycle 8. sdata stays 0 for the whole frame; lrck is high for slots 15..30.
- in_valid with in_data=16'hA5C3 before slot 0 → slots 0..15 shift out 1010010111000011 MSB first. Slots 16..31 repeat the same in mono. lrck rises at the fall event entering slot 15 and falls at the one entering slot 31.
- Strobe in_valid every 256 clk with BCLK_DIV=4 and the ramp 0x0000, 0x0001, … → every frame carries the previous strobe's value, with no underrun or overrun over 100 frames.
- Two in_valid strobes (0x1111, then 0x2222) within one frame → overrun pulses once; the next frame transmits 0x2222.
- in_valid in the same cycle as the slot-0 load → the load uses the old hold, no flag pulses, and the new value is sent in the following frame.
- Stereo build, L=16'h8000, R=16'h0001 → slot 0 = 1, slots 1..15 = 0, slots 16..30 = 0, slot 31 = 1. Also assert reset at slot 10: all outputs are 0 within the same cycle, and a clean restart follows.
